fetch_sequencer: RTL and testbench

//  Upstream control stage for the executor: holds the architectural PC, fetches one instruction per

---
 rtl/felis_pkg.sv | 23 ++
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/exec_watchdog.sv | 30 +++
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/felis_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding,
// instruction-word geometry and the default halt opcode.
package felis_pkg;

  localparam int INST_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE_DEFAULT = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INST_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus plus the executor control handshake, seen
// from the sequencer (master) and from the memory/executor side (slave).
interface fetch_sequencer_if;
  import felis_pkg::*;

  // Fetch: addr/valid stay stable until ready; ready may coincide with the
  // first valid cycle and completes the request with data on the same cycle.
  logic [INST_W-1:0] inst_mem_addr;
  logic              inst_mem_valid;
  logic [INST_W-1:0] inst_mem_data;
  logic              inst_mem_ready;
  logic              exec_reset;
  logic              exec_completed;
  logic [INST_W-1:0] exec_pc_out;

  modport master (
    output inst_mem_addr, inst_mem_valid, exec_reset,
    input  inst_mem_data, inst_mem_ready, exec_completed, exec_pc_out
  );

  modport slave (
    input  inst_mem_addr, inst_mem_valid, exec_reset,
    output inst_mem_data, inst_mem_ready, exec_completed, exec_pc_out
  );
endinterface

// File: rtl/exec_watchdog.sv
// Counts EXEC cycles and flags the last allowed one; TIMEOUT=0 never expires.
module exec_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && count_q != LAST) begin
      count_q <= count_q + 1'b1;
    end
  end

  // count_q holds (cycle index - 1), so LAST marks the TIMEOUT-th EXEC cycle.
  assign expired_o = (TIMEOUT != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Single-issue control stage: fetch, one decode cycle, then release the
// executor and wait for its completion before fetching the next PC.
module fetch_sequencer
  import felis_pkg::*;
#(
  parameter logic [INST_W-1:0]              RESET_PC    = 32'h0000_0000,
  parameter logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int unsigned                    TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  fetch_sequencer_if.master  bus,
  output logic [INST_W-1:0]  pc,
  output logic [INST_W-1:0]  inst,
  output logic               inst_valid,
  output logic               wb_en,
  output logic [INST_W-1:0]  retired,
  output logic               halted,
  output logic               error,
  output seq_state_t         dbg_state
);

  seq_state_t        state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] retired_q, retired_d;
  logic              in_exec;
  logic              wd_expired;

  assign in_exec = (state_q == ST_EXEC);

  exec_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (!in_exec),
    .enable_i  (in_exec),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    inst_d             = inst_q;
    retired_d          = retired_q;
    bus.inst_mem_addr  = pc_q;
    bus.inst_mem_valid = 1'b0;
    bus.exec_reset     = 1'b1;
    inst_valid         = 1'b0;
    wb_en              = 1'b0;
    halted             = 1'b0;
    error              = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        halted = (state_q == ST_HALT);
        error  = (state_q == ST_ERROR);
        if (start) begin
          pc_d      = RESET_PC;
          retired_d = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A misaligned PC never reaches the memory bus.
        if (pc_q[1:0] != 2'b00) begin
          state_d = ST_ERROR;
        end else begin
          bus.inst_mem_valid = 1'b1;
          if (bus.inst_mem_ready) begin
            inst_d  = bus.inst_mem_data;
            state_d = (opcode_of(bus.inst_mem_data) == HALT_OPCODE) ? ST_HALT : ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        inst_valid = 1'b1;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        inst_valid     = 1'b1;
        bus.exec_reset = 1'b0;
        // Completion on the watchdog's final cycle still retires the instruction.
        if (bus.exec_completed) begin
          pc_d      = bus.exec_pc_out;
          wb_en     = 1'b1;
          retired_d = retired_q + 1'b1;
          state_d   = ST_FETCH;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc        = pc_q;
  assign inst      = inst_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: acts as instruction memory and executor with
// randomized latencies, checked against an instruction-level program model.
module tb_fetch_sequencer;
  import felis_pkg::*;

  localparam int TO = 8;
  localparam int MAXS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc, inst, retired;
  logic        inst_valid, wb_en, halted, error;
  seq_state_t  dbg_state;

  fetch_sequencer_if bus_if ();

  fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'h3F),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .bus        (bus_if),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .wb_en      (wb_en),
    .retired    (retired),
    .halted     (halted),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wb_seen = 0;

  always @(posedge clk) if (wb_en) wb_seen <= wb_seen + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  // Program description and model expectations
  int          n_steps;
  logic [31:0] words [MAXS];
  logic [31:0] npc   [MAXS];
  int          lat_f [MAXS];
  int          lat_e [MAXS];
  logic [31:0] exp_q [$];
  int          exp_ret;
  logic        exp_halt, exp_err;
  logic [31:0] exp_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] halt_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h3F;
    return w;
  endfunction

  // Straight-line program: n-1 ordinary instructions, then a halt word.
  task automatic set_linear(input int n);
    n_steps = n;
    for (int i = 0; i < n; i++) begin
      words[i] = (i == n - 1) ? halt_word() : rand_word();
      lat_f[i] = 0;
      lat_e[i] = 1;
      npc[i]   = 32'(i * 4 + 4);
    end
  endtask

  task automatic set_random();
    logic [31:0] p;
    int k;
    p = 32'h0;
    n_steps = $urandom_range(2, 10);
    for (int i = 0; i < n_steps; i++) begin
      words[i] = (i == n_steps - 1) ? halt_word() : rand_word();
      lat_f[i] = $urandom_range(0, 4);
      lat_e[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, TO);
      k = $urandom_range(0, 15);
      if (k == 0)     npc[i] = p + 32'd2;
      else if (k < 4) npc[i] = 32'($urandom_range(0, 1023)) << 2;
      else            npc[i] = p + 32'd4;
      p = npc[i];
    end
  endtask

  // Instruction-level model: walks the program and records what must happen.
  task automatic build_model();
    logic [31:0] p;
    p = 32'h0;
    exp_q.delete();
    exp_ret  = 0;
    exp_halt = 1'b0;
    exp_err  = 1'b0;
    for (int i = 0; i < n_steps; i++) begin
      if (p % 4 != 0) begin exp_err = 1'b1; break; end
      exp_q.push_back(p);
      if (words[i][31:26] == 6'h3F) begin exp_halt = 1'b1; break; end
      if (lat_e[i] > TO) begin exp_err = 1'b1; break; end
      exp_ret++;
      p = npc[i];
    end
    exp_pc = p;
  endtask

  task automatic start_pulse();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_halted_clr", halted, 1'b0);
    check("start_error_clr", error, 1'b0);
    check("start_retired", retired, 32'h0);
    check("start_pc", pc, 32'h0);
  endtask

  // Drives one program. abort_mode 1: reset in EXEC of abort_step; 2: reset mid-fetch.
  task automatic run_program(input int abort_mode, input int abort_step);
    int w, lim, last_wb, wb_base;
    logic [31:0] a0;
    build_model();
    wb_base = wb_seen;
    last_wb = -1;
    start_pulse();
    for (int i = 0; i < n_steps; i++) begin
      w = 0;
      while (!bus_if.inst_mem_valid && !error && w < 20) begin tick(); w++; end
      if (w >= 20) begin check("fetch_wait", 32'(w), 32'(0)); break; end
      if (error) break;
      check("fetch_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("fetch_addr", bus_if.inst_mem_addr, exp_q.pop_front());
      a0 = bus_if.inst_mem_addr;
      for (int f = 0; f <= lat_f[i]; f++) begin
        check("fetch_valid_held", bus_if.inst_mem_valid, 1'b1);
        check("fetch_addr_held", bus_if.inst_mem_addr, a0);
        check("fetch_exec_rst", bus_if.exec_reset, 1'b1);
        if (abort_mode == 2 && i == abort_step && f == 1) begin
          rst_n = 1'b0;
          #1;
          check("rst_fetch_valid", bus_if.inst_mem_valid, 1'b0);
          check("rst_fetch_state", 32'(dbg_state), 32'(ST_IDLE));
          tick();
          rst_n = 1'b1;
          bus_if.inst_mem_ready = 1'b1;
          bus_if.inst_mem_data  = rand_word();
          tick();
          bus_if.inst_mem_ready = 1'b0;
          check("drop_resp_state", 32'(dbg_state), 32'(ST_IDLE));
          check("drop_resp_inst", inst, 32'h0);
          return;
        end
        bus_if.inst_mem_ready = (f == lat_f[i]);
        bus_if.inst_mem_data  = (f == lat_f[i]) ? words[i] : $urandom;
        tick();
      end
      bus_if.inst_mem_ready = 1'b0;
      if (words[i][31:26] == 6'h3F) begin
        check("halt_inst", inst, words[i]);
        break;
      end
      check("dec_inst_valid", inst_valid, 1'b1);
      check("dec_exec_rst", bus_if.exec_reset, 1'b1);
      check("dec_inst", inst, words[i]);
      check("dec_no_fetch", bus_if.inst_mem_valid, 1'b0);
      bus_if.exec_completed = $urandom_range(0, 1);
      bus_if.exec_pc_out    = $urandom;
      #1 check("dec_no_wb", wb_en, 1'b0);
      tick();
      lim = (lat_e[i] > TO) ? TO : lat_e[i];
      for (int c = 1; c <= lim; c++) begin
        check("exec_rst_low", bus_if.exec_reset, 1'b0);
        check("exec_no_error", error, 1'b0);
        if (abort_mode == 1 && i == abort_step) begin
          bus_if.exec_completed = 1'b0;
          rst_n = 1'b0;
          #1;
          check("rst_exec_rst", bus_if.exec_reset, 1'b1);
          check("rst_pc", pc, 32'h0);
          check("rst_retired", retired, 32'h0);
          check("rst_inst_valid", inst_valid, 1'b0);
          check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
          tick();
          rst_n = 1'b1;
          return;
        end
        bus_if.exec_completed = (c == lat_e[i]);
        bus_if.exec_pc_out    = (c == lat_e[i]) ? npc[i] : $urandom;
        #1;
        check("exec_wb_en", wb_en, (c == lat_e[i]));
        if (c == lat_e[i]) begin
          if (last_wb >= 0) check("wb_gap", 32'(cyc - last_wb), 32'(lat_f[i] + 2 + lat_e[i]));
          last_wb = cyc;
        end
        tick();
      end
      bus_if.exec_completed = 1'b0;
      if (lat_e[i] > TO) break;
    end
    w = 0;
    while (!halted && !error && w < 4) begin tick(); w++; end
    check("end_halted", halted, exp_halt);
    check("end_error", error, exp_err);
    check("end_retired", retired, 32'(exp_ret));
    check("end_pc", pc, exp_pc);
    check("end_exec_rst", bus_if.exec_reset, 1'b1);
    check("end_no_fetch", bus_if.inst_mem_valid, 1'b0);
    check("end_fetches_left", 32'(exp_q.size()), 32'(0));
    check("end_wb_count", 32'(wb_seen - wb_base), 32'(exp_ret));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus_if.inst_mem_ready = 1'b0;
    bus_if.inst_mem_data  = '0;
    bus_if.exec_completed = 1'b0;
    bus_if.exec_pc_out    = '0;
    repeat (3) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_exec_rst", bus_if.exec_reset, 1'b1);
    check("rst_mem_valid", bus_if.inst_mem_valid, 1'b0);
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_no_fetch", bus_if.inst_mem_valid, 1'b0);

    // Four back-to-back instructions, then halt
    set_linear(5);
    run_program(0, 0);

    // Slow memory on the first fetch
    set_linear(3);
    lat_f[0] = 5;
    run_program(0, 0);

    // Branch to 0x100, then a misaligned target
    set_linear(4);
    npc[0] = 32'h0000_0100;
    npc[1] = 32'h0000_0102;
    run_program(0, 0);

    // Halt word first, then restart refetches from 0
    set_linear(1);
    words[0] = 32'hFC00_0000;
    run_program(0, 0);
    set_linear(2);
    run_program(0, 0);

    // Watchdog: no completion, then completion on the final allowed cycle
    set_linear(3);
    lat_e[0] = TO + 1;
    run_program(0, 0);
    set_linear(3);
    lat_e[0] = TO;
    run_program(0, 0);

    // Reset mid-EXEC and mid-fetch
    set_linear(5);
    lat_e[2] = 3;
    run_program(1, 2);
    set_linear(4);
    lat_f[1] = 3;
    run_program(2, 1);

    for (int r = 0; r < 40; r++) begin
      set_random();
      run_program(0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
